// File: rtl/csr_enc_mul_arb_pkg.sv
// Shared constants and pipeline stage payload for the arbitrated multiplier.
package csr_enc_mul_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 14;
  localparam int unsigned LAT_DEF  = 4;
  localparam int unsigned IDW      = $clog2(NREQ_DEF);

  // One product-carrying pipeline slot: bubble flag, issuing requester, result.
  typedef struct packed {
    logic            valid;
    logic [IDW-1:0]  id;
    logic [W_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/csr_enc_mul_arb_rr.sv
// Round-robin requester pick and rotating priority pointer.
module csr_enc_mul_arb_rr
  import csr_enc_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic            adv,
  output logic [NREQ-1:0] ready_c,
  output logic            any_c,
  output logic [IDW-1:0]  grant_c
);

  logic [IDW-1:0] ptr;

  // First valid requester at or after ptr, wrapping; ready only while out of reset.
  always_comb begin
    int unsigned idx;
    any_c   = 1'b0;
    grant_c = '0;
    ready_c = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_c && req_valid[IDW'(idx)]) begin
        any_c   = 1'b1;
        grant_c = IDW'(idx);
      end
    end
    if (any_c && adv && reset) ready_c[grant_c] = 1'b1;
  end

  // Pointer moves past the winner only when its request actually transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (any_c && adv) begin
      ptr <= (grant_c == IDW'(NREQ - 1)) ? '0 : IDW'(grant_c + IDW'(1));
    end
  end

endmodule

// File: rtl/csr_enc_mul_arb.sv
// Shared signed multiplier fed by NREQ requesters through a round-robin arbiter,
// with a LAT-deep stallable pipeline and valid/ready result handshake.
module csr_enc_mul_arb
  import csr_enc_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned LAT  = LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [IDW-1:0]    out_id
);

  // Stages after the operand register; the last one drives the outputs.
  localparam int unsigned NDLY = LAT - 1;

  logic            ce_c;
  logic            any_c;
  logic [IDW-1:0]  grant_c;
  logic [W-1:0]    a_sel_c;
  logic [W-1:0]    b_sel_c;

  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  stage_t          stg [NDLY];

  // Whole pipeline advances together whenever the output slot is free or draining.
  assign ce_c      = ~out_valid | out_ready;
  assign out_valid = stg[NDLY-1].valid;
  assign out_id    = stg[NDLY-1].id;
  assign out_data  = stg[NDLY-1].data;

  csr_enc_mul_arb_rr #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .adv       (ce_c),
    .ready_c   (req_ready),
    .any_c     (any_c),
    .grant_c   (grant_c)
  );

  // Operand mux for the granted requester.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c == IDW'(i)) begin
        a_sel_c = req_a[i*W +: W];
        b_sel_c = req_b[i*W +: W];
      end
    end
  end

  // Operand register, product register, then pure delay; all hold on stall.
  // The low W bits of a product are the same for signed and unsigned operands,
  // so a W-bit multiply gives the wrapped two's-complement result directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      for (int unsigned i = 0; i < NDLY; i++) stg[i] <= '0;
    end else if (ce_c) begin
      s1_valid      <= any_c;
      s1_id         <= grant_c;
      s1_a          <= a_sel_c;
      s1_b          <= b_sel_c;
      stg[0].valid  <= s1_valid;
      stg[0].id     <= s1_id;
      stg[0].data   <= W'(s1_a * s1_b);
      for (int unsigned i = 1; i < NDLY; i++) stg[i] <= stg[i-1];
    end
  end

endmodule

// File: doc/csr_enc_mul_arb.md
CSR_ENC_MUL_ARB -- requirements
Module: csr_enc_mul_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the multiplier.
REQ-002 Parameter W, default 14: operand and product width in bits, signed.
REQ-003 Parameter LAT, default 4: multiplier pipeline depth in cycles.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset.
REQ-006 Port req_valid  input  NREQ: per-requester operation request.
REQ-007 Port req_ready  output  NREQ: per-requester accept; at most one bit high per cycle.
REQ-008 Port req_a  input  NREQ*W: per-requester operand A, packed, requester i at bits [i*W +: W].
REQ-009 Port req_b  input  NREQ*W: per-requester operand B, packed the same way as req_a.
REQ-010 Port out_valid  output  1: result present on out_data and out_id.
REQ-011 Port out_ready  input  1: downstream accepts the result.
REQ-012 Port out_data  output  W: signed product truncated to W bits.
REQ-013 Port out_id  output  clog2(NREQ): index of the requester that issued the result.

Function
REQ-014 Transfer rule: a request transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-015 Result rule: a result transfer occurs on an edge where out_valid and out_ready are both high.
REQ-016 Arbitration: round-robin, combinational over req_valid. The search starts at pointer ptr and wraps from NREQ-1 to 0.
REQ-017 Grant: the first valid requester found is the grant. req_ready[grant] = ce; all other req_ready bits are 0.
REQ-018 Pointer update: on a request transfer from requester g, ptr becomes (g+1) mod NREQ. With no transfer, ptr holds.
REQ-019 No-request case: if no req_valid bit is high, all req_ready bits are 0 and a bubble (valid=0) enters the pipeline.
REQ-020 Pipeline contents: LAT stages, each carrying valid, id and data.
  - Stage 1 registers the operands.
  - Stage 2 registers the full signed product, truncated to the low W bits.
  - Stages 3..LAT are pure delay.
  - The last stage drives out_valid, out_id and out_data.
REQ-021 Stall rule: ce = ~out_valid | out_ready. All pipeline stages advance only when ce=1, and hold otherwise, including bubbles.
REQ-022 Latency: a request accepted at edge T with no stalls gives out_valid=1 with its result after edge T+LAT. Each stall cycle adds exactly one cycle.
REQ-023 Throughput: one result per cycle sustained when out_ready is held high.
REQ-024 Ordering: results are delivered in acceptance order. No result is dropped or duplicated under any out_ready pattern.
REQ-025 Output stability: while out_valid=1 and out_ready=0, out_data and out_id hold stable.
REQ-026 Arithmetic: out_data = (A*B) mod 2^W, interpreted as two's complement. Overflow wraps with no saturation and no flag.
REQ-027 Simultaneous events: a result transfer and a request transfer in the same cycle are both legal and both take effect.
REQ-028 Combinational dependency: req_ready depends combinationally on out_ready, via ce, and on req_valid.

Reset
REQ-029 While reset=0: ptr=0, all stage valid bits=0, out_valid=0, out_data=0, out_id=0, req_ready=0.
REQ-030 Reset mid-operation discards all in-flight operations; no result for them is ever produced.
REQ-031 First request accepted after release of reset: requester 0 wins if it is valid.

Structure
REQ-032 Package csr_enc_mul_arb_pkg holds:
  - default constants NREQ, W, LAT;
  - IDW = clog2(NREQ);
  - a stage typedef {valid, id[IDW], data[W]}.
REQ-033 Sub-module csr_enc_mul_arb_rr implements the round-robin pick and pointer; all pipeline logic stays in the top.
REQ-034 Reference size: total RTL is 120-400 lines.

Verification
REQ-035 Single requester, latency: req 2 sends A=-3, B=5 at cycle 0, out_ready=1 -> out_valid=1, out_id=2, out_data=-15 exactly 4 cycles later.
REQ-036 Overflow wrap: A=100, B=100 -> out_data=-6384.
REQ-037 Fairness: all 4 requesters held valid for 8 accepts, starting from reset -> grant order 0,1,2,3,0,1,2,3, with one result per cycle.
REQ-038 Backpressure: out_ready=0 for 5 cycles with 4 operations in flight, then 1 ->
  - all req_ready are 0 during the stall;
  - out_data holds during the stall;
  - the 4 results emerge in order with no loss or duplication.
REQ-039 Reset mid-operation: assert reset with 3 operations in flight, then release -> out_valid stays 0 until a new request is accepted, and no stale ids appear.
REQ-040 Skip idle requesters: only req 1 and req 3 valid, ptr=2 -> grants 3,1,3,1, and no requester is starved.
